d_capture_bank: RTL and testbench

//   Parametrised successor to the single-bit gated D latch: a WIDTH-bit storage

---
 rtl/d_capture_bank.sv | 150 +++++++++++++++
 tb/tb_d_capture_bank.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_capture_bank.sv
// -----------------------------------------------------------------------------
// d_capture_bank
//   WIDTH-bit storage element that replaces a single-bit gated D latch. All
//   logic runs on Clk. The asynchronous Gate and D switches are synchronised
//   first. Mode picks one of two behaviours:
//     Mode 0 : Q tracks D while the synchronised gate is high. The value held
//              when the gate closes is pushed into the history.
//     Mode 1 : Q captures D on a synchronised gate rising edge, and that value
//              is pushed into the history in the same cycle.
//   The history is a DEPTH-entry shift buffer. Entry 0 is the newest. Entries
//   are read combinationally through Sel.
//
// Ports
//   Clk     in   1                 system clock, all state on rising edge
//   Resetn  in   1                 asynchronous active-low reset
//   Gate    in   1                 asynchronous gate switch
//   D       in   WIDTH             asynchronous data switches
//   Mode    in   1                 0 = transparent latch, 1 = edge-triggered
//   Clr     in   1                 synchronous clear of history and Count
//   Sel     in   $clog2(DEPTH)     history read index, 0 = newest
//   Q       out  WIDTH             currently stored value
//   Hist    out  WIDTH             history entry Sel, or 0 if Sel >= Count
//   Count   out  $clog2(DEPTH+1)   valid history entries, saturates at DEPTH
//   Cap     out  1                 one-cycle pulse in the cycle a push is visible
// -----------------------------------------------------------------------------
module d_capture_bank #(
  parameter  int WIDTH       = 8,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int SEL_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             Gate,
  input  logic [WIDTH-1:0] D,
  input  logic             Mode,
  input  logic             Clr,
  input  logic [SEL_W-1:0] Sel,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Hist,
  output logic [CNT_W-1:0] Count,
  output logic             Cap
);

  // Synchroniser chains. Stage 0 samples the pin, and the last stage is used.
  // Gate and D share the same depth, so gate_s and d_s stay aligned.
  logic [SYNC_STAGES-1:0]            gate_sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] d_sync_q;
  logic                              gate_s;
  logic [WIDTH-1:0]                  d_s;
  logic                              gate_prev_q;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             cap_q, cap_d;

  logic             rise, fall;
  logic             push;
  logic [WIDTH-1:0] push_val;

  assign gate_s = gate_sync_q[SYNC_STAGES-1];
  assign d_s    = d_sync_q[SYNC_STAGES-1];
  assign rise   = gate_s & ~gate_prev_q;
  assign fall   = ~gate_s & gate_prev_q;

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its pre-edge inputs and the chain shifts one stage per clock.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      gate_sync_q <= '0;
      d_sync_q    <= '0;
      gate_prev_q <= 1'b0;
    end else begin
      gate_sync_q <= {gate_sync_q[SYNC_STAGES-2:0], Gate};
      d_sync_q    <= {d_sync_q[SYNC_STAGES-2:0], D};
      gate_prev_q <= gate_s;
    end
  end

  // Capture and push decision. Mode is used directly, so changing Mode never
  // creates an edge of its own.
  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    q_d      = q_q;
    push     = 1'b0;
    push_val = q_q;
    if (!Mode) begin
      // The falling edge implies gate_s == 0, so Q is not reloaded in that
      // cycle. The pushed value is the one held at closing.
      if (gate_s) q_d = d_s;
      if (fall) begin
        push     = 1'b1;
        push_val = q_q;
      end
    end else if (rise) begin
      q_d      = d_s;
      push     = 1'b1;
      push_val = d_s;
    end
  end

  // History shift and count. Clr overrides a push in the same cycle.
  always_comb begin
    hist_d  = hist_q;
    count_d = count_q;
    cap_d   = 1'b0;
    if (Clr) begin
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      count_d = '0;
    end else if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = push_val;
      count_d   = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
      cap_d     = 1'b1;
    end
  end

  // NOTE: the history array is reset explicitly. Reset must clear every
  // entry immediately, so it is built from resettable flops, not a RAM.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      q_q     <= '0;
      count_q <= '0;
      cap_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      cap_q   <= cap_d;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
    end
  end

  // Read port. Entries at or beyond Count read as zero. This also covers
  // Sel >= DEPTH when DEPTH is not a power of two.
  always_comb begin
    Hist = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(Sel) == i && i < int'(count_q)) Hist = hist_q[i];
    end
  end

  assign Q     = q_q;
  assign Count = count_q;
  assign Cap   = cap_q;

endmodule

// File: tb/tb_d_capture_bank.sv
// -----------------------------------------------------------------------------
// tb_d_capture_bank
//   Directed bench for d_capture_bank (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
//   A queue-based model predicts Q, Hist, Count and Cap. Those are compared on
//   every falling clock edge. Directed steps also check hand-computed literals.
// -----------------------------------------------------------------------------
module tb_d_capture_bank;

  localparam int W   = 8;
  localparam int DEP = 4;
  localparam int S   = 2;

  logic         Clk    = 1'b0;
  logic         Resetn = 1'b0;
  logic         Gate   = 1'b0;
  logic [W-1:0] D      = '0;
  logic         Mode   = 1'b0;
  logic         Clr    = 1'b0;
  logic [1:0]   Sel    = '0;
  logic [W-1:0] Q;
  logic [W-1:0] Hist;
  logic [2:0]   Count;
  logic         Cap;

  int checks   = 0;
  int failures = 0;

  d_capture_bank #(.WIDTH(W), .DEPTH(DEP), .SYNC_STAGES(S)) dut (
    .Clk(Clk), .Resetn(Resetn), .Gate(Gate), .D(D), .Mode(Mode), .Clr(Clr),
    .Sel(Sel), .Q(Q), .Hist(Hist), .Count(Count), .Cap(Cap)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_gq/m_dq are input delay lines. Element 0 is the value the synchronised
  // signal shows during the current cycle.
  bit           m_gq[$];
  logic [W-1:0] m_dq[$];
  bit           m_gp  = 1'b0;
  logic [W-1:0] m_q   = '0;
  logic [W-1:0] m_h[$];
  bit           m_cap = 1'b0;

  initial begin
    for (int i = 0; i < S; i++) begin
      m_gq.push_back(1'b0);
      m_dq.push_back('0);
    end
  end

  function automatic logic [W-1:0] exp_hist(input int sel);
    if (sel < m_h.size()) return m_h[sel];
    return '0;
  endfunction

  always @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      m_gq.delete();
      m_dq.delete();
      for (int i = 0; i < S; i++) begin
        m_gq.push_back(1'b0);
        m_dq.push_back('0);
      end
      m_gp  = 1'b0;
      m_q   = '0;
      m_h.delete();
      m_cap = 1'b0;
    end else begin
      bit           gs, push;
      logic [W-1:0] ds, val;
      gs   = m_gq[0];
      ds   = m_dq[0];
      push = 1'b0;
      val  = '0;
      if (!Mode) begin
        if (!gs && m_gp) begin push = 1'b1; val = m_q; end
        if (gs) m_q = ds;
      end else if (gs && !m_gp) begin
        m_q  = ds;
        push = 1'b1;
        val  = ds;
      end
      if (Clr) begin
        m_h.delete();
        m_cap = 1'b0;
      end else if (push) begin
        m_h.push_front(val);
        if (m_h.size() > DEP) void'(m_h.pop_back());
        m_cap = 1'b1;
      end else begin
        m_cap = 1'b0;
      end
      m_gp = gs;
      void'(m_gq.pop_front());
      void'(m_dq.pop_front());
      m_gq.push_back(Gate);
      m_dq.push_back(D);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    check("cyc_Q",     {24'd0, Q},     {24'd0, m_q});
    check("cyc_Count", {29'd0, Count}, m_h.size());
    check("cyc_Cap",   {31'd0, Cap},   {31'd0, m_cap});
    check("cyc_Hist",  {24'd0, Hist},  {24'd0, exp_hist(int'(Sel))});
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_edges(3);
    Resetn = 1'b1;
    wait_edges(3);

    // Mode 1 capture, A5, with the synchroniser latency.
    Mode = 1'b1; D = 8'hA5; Gate = 1'b1;
    wait_edges(S);
    check("m1_Q_before", {24'd0, Q}, 32'h00);
    check("m1_Cap_before", {31'd0, Cap}, 32'd0);
    wait_edges(1);
    check("m1_Q", {24'd0, Q}, 32'hA5);
    check("m1_Cap", {31'd0, Cap}, 32'd1);
    check("m1_Count", {29'd0, Count}, 32'd1);
    check("m1_Hist0", {24'd0, Hist}, 32'hA5);
    D = 8'h3C;
    wait_edges(4);
    check("m1_Q_hold", {24'd0, Q}, 32'hA5);
    check("m1_Cap_once", {31'd0, Cap}, 32'd0);
    Gate = 1'b0;
    wait_edges(4);

    // Mode 0, transparent latch.
    Mode = 1'b0; D = 8'h01; Gate = 1'b1;
    wait_edges(S + 1);
    check("m0_Q_01", {24'd0, Q}, 32'h01);
    D = 8'h02;
    wait_edges(S);
    check("m0_Q_lag", {24'd0, Q}, 32'h01);
    wait_edges(1);
    check("m0_Q_02", {24'd0, Q}, 32'h02);
    D = 8'h03;
    wait_edges(S + 1);
    check("m0_Q_03", {24'd0, Q}, 32'h03);
    Gate = 1'b0;
    wait_edges(S + 1);
    check("m0_Cap", {31'd0, Cap}, 32'd1);
    check("m0_Hist0", {24'd0, Hist}, 32'h03);
    check("m0_Count", {29'd0, Count}, 32'd2);
    wait_edges(1);
    check("m0_Cap_once", {31'd0, Cap}, 32'd0);
    D = 8'h55;
    wait_edges(4);
    check("m0_Q_hold", {24'd0, Q}, 32'h03);

    // Overflow: six captures into four entries.
    Mode = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      D = 8'(v); Gate = 1'b1;
      wait_edges(4);
      Gate = 1'b0;
      wait_edges(4);
    end
    check("ovf_Count", {29'd0, Count}, 32'd4);
    for (int s = 0; s < 4; s++) begin
      Sel = 2'(s);
      #1;
      check($sformatf("ovf_Hist%0d", s), {24'd0, Hist}, 32'(6 - s));
    end
    Sel = 2'd0;

    // Clr in the same cycle as a capture rise.
    D = 8'h77; Gate = 1'b1;
    wait_edges(S);
    Clr = 1'b1;
    wait_edges(1);
    Clr = 1'b0;
    check("clr_Q", {24'd0, Q}, 32'h77);
    check("clr_Count", {29'd0, Count}, 32'd0);
    check("clr_Cap", {31'd0, Cap}, 32'd0);
    for (int s = 0; s < 4; s++) begin
      Sel = 2'(s);
      #1;
      check($sformatf("clr_Hist%0d", s), {24'd0, Hist}, 32'h00);
    end
    Sel = 2'd0;
    Gate = 1'b0;
    wait_edges(4);

    // Sel beyond Count reads zero.
    D = 8'h88; Gate = 1'b1;
    wait_edges(4);
    Gate = 1'b0;
    wait_edges(4);
    check("sel_Count", {29'd0, Count}, 32'd1);
    Sel = 2'd2;
    #1;
    check("sel2_Hist", {24'd0, Hist}, 32'h00);
    Sel = 2'd0;
    #1;
    check("sel0_Hist", {24'd0, Hist}, 32'h88);

    // Asynchronous reset mid-gate, then Gate held high through release.
    D = 8'h9E; Gate = 1'b1;
    wait_edges(4);
    Resetn = 1'b0;
    #1;
    check("rst_Q", {24'd0, Q}, 32'h00);
    check("rst_Count", {29'd0, Count}, 32'd0);
    check("rst_Hist", {24'd0, Hist}, 32'h00);
    check("rst_Cap", {31'd0, Cap}, 32'd0);
    wait_edges(3);
    D = 8'hC4;
    Resetn = 1'b1;
    wait_edges(S);
    check("rel_Q_before", {24'd0, Q}, 32'h00);
    check("rel_Cap_before", {31'd0, Cap}, 32'd0);
    wait_edges(1);
    check("rel_Q", {24'd0, Q}, 32'hC4);
    check("rel_Cap", {31'd0, Cap}, 32'd1);
    check("rel_Count", {29'd0, Count}, 32'd1);
    wait_edges(4);
    check("rel_Count_once", {29'd0, Count}, 32'd1);
    check("rel_Cap_once", {31'd0, Cap}, 32'd0);
    Gate = 1'b0;
    wait_edges(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
